// File: rtl/fp_cond_unit.sv
// -----------------------------------------------------------------------------
// fp_cond_unit
// Sequencer and condition-flag holder for single-precision FP compares
// (c.eq.s, c.lt.s, c.le.s, c.f.s) and the FP branches bc1t/bc1f.
//
// A compare is a fixed three-state walk: IDLE latches the operands, WAIT
// gives the external comparator a full cycle to settle and samples its
// relation, and DONE evaluates the condition and writes FCC.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, op, fs, ft compare issue (op: 00 eq, 01 lt, 10 le, 11 f)
//   cmp_a, cmp_b      registered operands to the compare datapath
//   cmp_result        one-hot relation from datapath: 100 gt, 010 eq, 001 lt
//   busy, done        compare in flight / one-cycle FCC-updated pulse
//   fcc               FP condition flag
//   fcc_we, fcc_wd    direct FCC write (ctc1)
//   bc_req, bc_tf     branch query (bc_tf=1 for bc1t)
//   bc_taken,bc_stall combinational branch resolution
//   exc, exc_clr      sticky illegal-relation flag and its clear
//   cmp_count         completed-compare counter, wraps
// -----------------------------------------------------------------------------
module fp_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [31:0]      fs,
    input  logic [31:0]      ft,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic [2:0]       cmp_result,
    output logic             busy,
    output logic             done,
    output logic             fcc,
    input  logic             fcc_we,
    input  logic             fcc_wd,
    input  logic             bc_req,
    input  logic             bc_tf,
    output logic             bc_taken,
    output logic             bc_stall,
    output logic             exc,
    input  logic             exc_clr,
    output logic [CNT_W-1:0] cmp_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [31:0]      cmp_a_r;
    logic [31:0]      cmp_b_r;
    logic [1:0]       op_r;
    logic [2:0]       res_r;
    logic             done_r;
    logic             fcc_r;
    logic             exc_r;
    logic [CNT_W-1:0] count_r;
    logic             legal_s;
    logic             cond_s;

    // A relation is legal only if it is exactly one-hot.
    function automatic logic is_legal(input logic [2:0] rel);
        logic ok;
        case (rel)
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Condition requested by op, given a legal one-hot relation.
    function automatic logic eval_cond(input logic [1:0] opc, input logic [2:0] rel);
        logic c;
        case (opc)
            2'b00:   c = (rel == 3'b010);
            2'b01:   c = (rel == 3'b001);
            2'b10:   c = (rel == 3'b001) || (rel == 3'b010);
            2'b11:   c = 1'b0;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Next-state logic: each compare walks IDLE -> WAIT -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Condition evaluation from the sampled relation; illegal relations force 0.
    always_comb begin
        legal_s = is_legal(res_r);
        cond_s  = 1'b0;
        if (legal_s) begin
            cond_s = eval_cond(op_r, res_r);
        end else begin
            cond_s = 1'b0;
        end
    end

    // State register and done pulse (done follows the DONE state by one edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == ST_DONE);
        end
    end

    // Operand/op latch on accept and relation sample in WAIT; start while busy is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_a_r <= 32'h0000_0000;
            cmp_b_r <= 32'h0000_0000;
            op_r    <= 2'b00;
            res_r   <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cmp_a_r <= fs;
                        cmp_b_r <= ft;
                        op_r    <= op;
                    end
                end
                ST_WAIT: res_r <= cmp_result;
                default: ;
            endcase
        end
    end

    // FCC: the compare write in DONE takes precedence over a direct write.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcc_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            fcc_r <= cond_s;
        end else if (fcc_we) begin
            fcc_r <= fcc_wd;
        end
    end

    // Sticky exception: a set in DONE beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_r <= 1'b0;
        end else if ((state_r == ST_DONE) && !legal_s) begin
            exc_r <= 1'b1;
        end else if (exc_clr) begin
            exc_r <= 1'b0;
        end
    end

    // Completed-compare counter; natural wrap at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (state_r == ST_DONE) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign cmp_a     = cmp_a_r;
    assign cmp_b     = cmp_b_r;
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign fcc       = fcc_r;
    assign exc       = exc_r;
    assign cmp_count = count_r;
    assign bc_taken  = bc_req & ~busy & (fcc_r == bc_tf);
    assign bc_stall  = bc_req & busy;

endmodule

// File: tb/tb_fp_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_fp_cond_unit
// Directed, table-driven bench for fp_cond_unit. A second instance with a
// 2-bit counter shares all inputs so the counter wrap is reachable in a short
// run. Each table row is one full compare with hand-computed FCC/exc results;
// flags add conflicts inside the compare:
//   flags[0] start re-asserted (new operands) while in WAIT
//   flags[1] fcc_we=1, fcc_wd=1 during the DONE cycle
//   flags[2] exc_clr=1 during the DONE cycle
// -----------------------------------------------------------------------------
module tb_fp_cond_unit;

    logic        clk = 1'b0;
    logic        rst, start, fcc_we, fcc_wd, bc_req, bc_tf, exc_clr;
    logic [1:0]  op;
    logic [31:0] fs, ft;
    logic [2:0]  cmp_result;

    logic [31:0] cmp_a, cmp_b, s_cmp_a, s_cmp_b;
    logic        busy, done, fcc, bc_taken, bc_stall, exc;
    logic        s_busy, s_done, s_fcc, s_bc_taken, s_bc_stall, s_exc;
    logic [15:0] cmp_count;
    logic [1:0]  s_cmp_count;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    fp_cond_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .fs(fs), .ft(ft),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_result(cmp_result),
        .busy(busy), .done(done), .fcc(fcc), .fcc_we(fcc_we), .fcc_wd(fcc_wd),
        .bc_req(bc_req), .bc_tf(bc_tf), .bc_taken(bc_taken), .bc_stall(bc_stall),
        .exc(exc), .exc_clr(exc_clr), .cmp_count(cmp_count)
    );

    fp_cond_unit #(.CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .start(start), .op(op), .fs(fs), .ft(ft),
        .cmp_a(s_cmp_a), .cmp_b(s_cmp_b), .cmp_result(cmp_result),
        .busy(s_busy), .done(s_done), .fcc(s_fcc), .fcc_we(fcc_we), .fcc_wd(fcc_wd),
        .bc_req(bc_req), .bc_tf(bc_tf), .bc_taken(s_bc_taken), .bc_stall(s_bc_stall),
        .exc(s_exc), .exc_clr(exc_clr), .cmp_count(s_cmp_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] fs;
        logic [31:0] ft;
        logic [2:0]  res;
        logic [2:0]  flags;
        logic        exp_fcc;
        logic        exp_exc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete compare, started one cycle after an edge so it is accepted at E0.
    task automatic do_cmp(input vec_t v);
        logic [15:0] ec;
        start      = 1'b1;
        op         = v.op;
        fs         = v.fs;
        ft         = v.ft;
        cmp_result = 3'b111;
        bc_req     = 1'b1;
        bc_tf      = 1'b1;
        step(); // E0
        chk("busy_e0", 32'(busy), 32'd1);
        chk("done_e0", 32'(done), 32'd0);
        chk("cmp_a_e0", cmp_a, v.fs);
        chk("cmp_b_e0", cmp_b, v.ft);
        chk("stall_e0", 32'(bc_stall), 32'd1);
        chk("taken_e0", 32'(bc_taken), 32'd0);
        cmp_result = v.res;
        if (v.flags[0]) begin
            start = 1'b1;
            fs    = ~v.fs;
            ft    = ~v.ft;
        end else begin
            start = 1'b0;
        end
        step(); // E1
        start      = 1'b0;
        cmp_result = 3'b111;
        chk("busy_e1", 32'(busy), 32'd1);
        chk("cmp_a_e1", cmp_a, v.fs);
        chk("stall_e1", 32'(bc_stall), 32'd1);
        fcc_we  = v.flags[1];
        fcc_wd  = v.flags[1];
        exc_clr = v.flags[2];
        step(); // E2
        fcc_we  = 1'b0;
        fcc_wd  = 1'b0;
        exc_clr = 1'b0;
        exp_count++;
        ec = 16'(exp_count);
        chk("done_e2", 32'(done), 32'd1);
        chk("busy_e2", 32'(busy), 32'd0);
        chk("fcc", 32'(fcc), 32'(v.exp_fcc));
        chk("exc", 32'(exc), 32'(v.exp_exc));
        chk("count", 32'(cmp_count), 32'(ec));
        chk("count_small", 32'(s_cmp_count), 32'(ec[1:0]));
        bc_tf = v.exp_fcc;
        #1;
        chk("taken_match", 32'(bc_taken), 32'd1);
        chk("stall_idle", 32'(bc_stall), 32'd0);
        bc_tf = ~v.exp_fcc;
        #1;
        chk("taken_nomatch", 32'(bc_taken), 32'd0);
        bc_req = 1'b0;
    endtask

    initial begin
        vec_t v;
        //          op     fs            ft            res     flags   fcc   exc
        tbl[0]  = '{2'b00, 32'h3F800000, 32'h3F800000, 3'b010, 3'b000, 1'b1, 1'b0};
        tbl[1]  = '{2'b01, 32'hBF800000, 32'h40000000, 3'b001, 3'b000, 1'b1, 1'b0};
        tbl[2]  = '{2'b00, 32'hBF800000, 32'h40000000, 3'b001, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{2'b11, 32'h3F800000, 32'h3F800000, 3'b010, 3'b000, 1'b0, 1'b0};
        tbl[4]  = '{2'b10, 32'h40000000, 32'h3F800000, 3'b100, 3'b000, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 32'h3F800000, 32'h3F800000, 3'b010, 3'b001, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 32'h40000000, 32'h3F800000, 3'b100, 3'b010, 1'b0, 1'b0};
        tbl[7]  = '{2'b10, 32'hBF800000, 32'h40000000, 3'b001, 3'b000, 1'b1, 1'b0};
        tbl[8]  = '{2'b00, 32'h00000000, 32'h00000000, 3'b011, 3'b000, 1'b0, 1'b1};
        tbl[9]  = '{2'b01, 32'hBF800000, 32'h40000000, 3'b001, 3'b100, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 32'h3F800000, 32'h3F800000, 3'b000, 3'b100, 1'b0, 1'b1};
        tbl[11] = '{2'b10, 32'h3F800000, 32'h40000000, 3'b110, 3'b000, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; op = 2'b00; fs = 32'h0; ft = 32'h0;
        cmp_result = 3'b000; fcc_we = 1'b0; fcc_wd = 1'b0;
        bc_req = 1'b0; bc_tf = 1'b0; exc_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_cmp_a", cmp_a, 32'h0);
        chk("rst_cmp_b", cmp_b, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fcc", 32'(fcc), 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_count", 32'(cmp_count), 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_cmp(tbl[i]);
        end
        // Back-to-back rows above start one cycle after E2, so they are accepted at E3.

        // exc is sticky until cleared
        step();
        step();
        chk("exc_sticky", 32'(exc), 32'd1);
        exc_clr = 1'b1;
        step();
        exc_clr = 1'b0;
        chk("exc_cleared", 32'(exc), 32'd0);

        // direct FCC write in IDLE
        fcc_we = 1'b1; fcc_wd = 1'b1;
        step();
        chk("fcc_we_idle_1", 32'(fcc), 32'd1);
        fcc_wd = 1'b0;
        step();
        fcc_we = 1'b0;
        chk("fcc_we_idle_0", 32'(fcc), 32'd0);

        // reset in WAIT aborts the compare
        start = 1'b1; op = 2'b00; fs = 32'h3F800000; ft = 32'h3F800000;
        step(); // E0
        start = 1'b0; cmp_result = 3'b010; rst = 1'b1;
        step(); // E1 under reset
        rst = 1'b0;
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_fcc", 32'(fcc), 32'd0);
        chk("rstw_count", 32'(cmp_count), 32'd0);
        step();
        chk("rstw_no_done", 32'(done), 32'd0);
        chk("rstw_fcc_after", 32'(fcc), 32'd0);

        // reset in DONE aborts the compare
        start = 1'b1;
        step(); // E0
        start = 1'b0;
        step(); // E1 samples 010
        rst = 1'b1;
        step(); // E2 under reset
        rst = 1'b0;
        chk("rstd_done", 32'(done), 32'd0);
        chk("rstd_fcc", 32'(fcc), 32'd0);
        step();
        chk("rstd_no_done", 32'(done), 32'd0);
        chk("rstd_count", 32'(cmp_count), 32'd0);

        // recovery after reset
        exp_count = 0;
        v = tbl[0];
        do_cmp(v);
        step();
        chk("done_drops", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_cond_unit.md
# fp_cond_unit

Sequencer and condition-flag holder for MIPS floating-point compare instructions (c.eq.s, c.lt.s, c.le.s, c.f.s) and the branches bc1t/bc1f.
- Latches two single-precision operands and drives them to the FP compare datapath.
- Samples that datapath's 3-bit one-hot relation after one settle cycle and evaluates the requested condition.
- Writes the result into the FP condition flag (FCC).
- Serves branch queries against FCC and stalls them while a compare is in flight.
- Sits downstream of the FP register file read and upstream of the branch resolution logic.

## Interface
Parameters:
- CNT_W, 16, width of the completed-compare counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  issue a compare; accepted only when busy=0
- op  in  2  condition: 00 eq, 01 lt, 10 le, 11 f (always false)
- fs  in  32  first operand (IEEE-754 single)
- ft  in  32  second operand
- cmp_a  out  32  registered operand A to compare datapath
- cmp_b  out  32  registered operand B to compare datapath
- cmp_result  in  3  relation of cmp_a vs cmp_b: 100 greater, 010 equal, 001 less
- busy  out  1  compare in flight
- done  out  1  one-cycle pulse: FCC updated by a compare
- fcc  out  1  FP condition flag
- fcc_we  in  1  direct FCC write (ctc1)
- fcc_wd  in  1  direct FCC write data
- bc_req  in  1  branch on FCC being resolved
- bc_tf  in  1  1 = bc1t, 0 = bc1f
- bc_taken  out  1  combinational: bc_req & ~busy & (fcc == bc_tf)
- bc_stall  out  1  combinational: bc_req & busy
- exc  out  1  sticky: illegal cmp_result sampled
- exc_clr  in  1  clears exc
- cmp_count  out  CNT_W  number of completed compares; wraps

## Operation
- FSM states: IDLE, WAIT, DONE. busy = (state != IDLE).
- IDLE:
  - When start=1: latch fs→cmp_a, ft→cmp_b, op→op_q, then go to WAIT.
  - When start=0: stay in IDLE.
- WAIT: unconditionally sample cmp_result into res_q, then go to DONE. cmp_a/cmp_b are held stable throughout.
- DONE: evaluate cond from res_q and op_q, write fcc ← cond, pulse done, cmp_count ← cmp_count+1, then go to IDLE.
- Condition evaluation:
  - eq: res_q==010
  - lt: res_q==001
  - le: res_q==001 or 010
  - f: 0
- Illegal result: if res_q is not one of {100, 010, 001}, fcc ← 0 and exc ← 1. done and cmp_count still update.
- start while busy is ignored. It is not queued and raises no flag.
- Direct write: fcc_we=1 writes fcc_wd in any state, except in DONE, where the compare write wins and fcc_we is dropped.
- exc: set has priority over exc_clr in the same cycle.
- cmp_count wraps from 2^CNT_W−1 to 0.

## Timing
- Edge E0: start accepted in IDLE. busy=1 from E0.
- Edge E1: cmp_result sampled. The comparator has the full cycle after E0 to settle.
- Edge E2: fcc, exc and cmp_count updated. done=1 for the cycle after E2. busy=0 after E2.
- Next start is accepted at E3. Throughput is one compare per 3 cycles; latency is start-to-fcc 2 edges.
- Branch resolution: bc_taken and bc_stall are combinational on the current fcc. A branch in the cycle after E2 sees the new fcc.
- Reset values: state=IDLE, cmp_a=0, cmp_b=0, busy=0, done=0, fcc=0, exc=0, cmp_count=0.
- Reset in WAIT or DONE aborts the compare: no fcc write, no done pulse, no count.
- rst has priority over start, fcc_we and exc_clr.

## Test plan
- Equal operands:
  - Stimulus: op=00, fs=ft=0x3F800000 (1.0), cmp_result=010.
  - Response: done pulses after E2, fcc=1, cmp_count=1; bc_req=1, bc_tf=1 → bc_taken=1.
- Less-than:
  - Stimulus: op=01, fs=0xBF800000 (−1.0), ft=0x40000000 (2.0), cmp_result=001.
  - Response: fcc=1, then op=00 with same operands → fcc=0; op=11 → fcc=0 regardless of result.
- Branch stall:
  - Stimulus: bc_req=1 held during E0–E2 of an le compare with cmp_result=100.
  - Response: bc_stall=1 while busy, bc_taken=0; after E2, fcc=0, bc_tf=0 → bc_taken=1.
- Conflicts:
  - start asserted in WAIT: ignored; cmp_a unchanged.
  - fcc_we=1, fcc_wd=1 in DONE with lt false: fcc=0. Same write in IDLE: fcc=1.
- Illegal result:
  - Stimulus: cmp_result=011.
  - Response: fcc=0, exc=1, done pulses; exc stays 1 until exc_clr=1.
- Reset mid-operation:
  - Stimulus: rst in WAIT; separately, cmp_count at 0xFFFF completes a compare.
  - Response: rst returns busy=0 with fcc unchanged from its reset value 0, and no done. The counter wraps to 0x0000.
